local_spike_sink: RTL and testbench
===================================

// Module: local_spike_sink
// PURPOSE
//  Downstream consumer of the local-delivery buffers of the north and south forwarding stages.
//  Round-robin pops packets from both, extracts the axon index, and sets that bit in a
//  double-banked axon spike bitmap feeding the neuron core. The global tick swaps the banks.
//  Spikes received in tick N are presented to the core during tick N+1.
// PARAMETERS
//  LOCAL_WIDTH  12   width of a local packet (router packet minus dy field)
//  AXON_MSB     7    MSB of the axon index field; the field is [AXON_MSB:0]
//  NUM_AXONS    256  bitmap size; must be <= 2**(AXON_MSB+1)
//  CNT_WIDTH    16   width of the per-tick spike counters
// PORTS
//  clk              in   1            single clock, rising edge
//  reset            in   1            asynchronous, active-high
//  din_north        in   LOCAL_WIDTH  north local buffer head (FWFT: valid while !empty_north)
//  empty_north      in   1            north local buffer empty
//  ren_north        out  1            pop north local buffer
//  din_south        in   LOCAL_WIDTH  south local buffer head (FWFT)
//  empty_south      in   1            south local buffer empty
//  ren_south        out  1            pop south local buffer
//  tick             in   1            one-cycle pulse: end of current timestep
//  axon_spikes      out  NUM_AXONS    active bank; stable for one whole tick
//  spike_count      out  CNT_WIDTH    accepted packets in the previous tick (latched at tick)
//  range_error      out  1            sticky: an axon index >= NUM_AXONS was received
// BEHAVIOUR
//  Reset: ren_*=0, both banks=0, bank_sel=0, spike_count=0, range_error=0, rr_ptr=north,
//   internal counter=0. Reset mid-operation aborts at once; no pop completes in that cycle.
//  Pop: a combinational grant, at most one pop per cycle. ren_x=1 only when !empty_x and x is granted.
//  Arbitration: if only one side is non-empty, that side is granted. If both are non-empty,
//   rr_ptr is granted and rr_ptr then flips to the other side. rr_ptr does not change on a
//   single-requester grant. Starvation bound: 1 cycle.
//  Data is sampled from din_x in the same cycle as ren_x (FWFT). Throughput is 1 packet/cycle.
//  Write: idx=din[AXON_MSB:0].
//   If idx<NUM_AXONS: fill_bank[idx]<=1 at the next edge; spike_cnt+1.
//   Else: drop the packet (it is still popped), set range_error, and do not increment.
//  Duplicate axon index within a tick: the bit stays 1 (OR); each duplicate counts.
//  Banks: fill_bank = bank[~bank_sel], axon_spikes = bank[bank_sel].
//  On tick at edge E:
//   - bank_sel toggles.
//   - The new fill bank (the previous active bank) is cleared.
//   - spike_count <= spike_cnt + (valid pop this cycle ? 1 : 0).
//   - spike_cnt <= 0.
//  A pop in the tick cycle belongs to the ending tick. It is written into the bank becoming
//   active, so it appears on axon_spikes from E+1. The clear of the other bank is unaffected.
//  Latency: pop at cycle t (no tick) -> fill bit set at t+1 -> visible on axon_spikes the
//   cycle after the next tick edge.
//  Counter saturates at 2**CNT_WIDTH-1; no wrap.
//  Back-to-back ticks (tick on consecutive cycles) are legal. Each tick swaps banks; an empty
//   tick yields an all-zero bank and spike_count=0.
//  Empty inputs: ren_* stay 0, state holds. ren_* are never asserted while the matching empty=1.
//  range_error is cleared only by reset.
// STRUCTURE
//  Shared package/header: LOCAL_WIDTH, AXON_MSB, NUM_AXONS, field positions of the local packet
//   (shared with the forwarding stage so the widths agree).
//  Sub-module rr_arbiter2: 2-requester round-robin, req[1:0] -> grant[1:0], ptr register.
//   Reusable in the Merge stages.
//  Top: arbiter, data mux, index decode/range check, bank registers, bank_sel, counters.
// TESTING
//  1 Single pop: north pushes idx 5, then tick
//    -> ren_north 1 cycle; axon_spikes[5]=1 from the cycle after tick; spike_count=1.
//  2 Contention: both sides non-empty for 4 packets each (N:1,2,3,4; S:10,11,12,13)
//    -> grants alternate N,S,N,S...; 8 pops in 8 cycles; after tick bits {1-4,10-13} set, count=8.
//  3 Pop on tick cycle: pop idx 7 in the same cycle as tick
//    -> axon_spikes[7]=1 at E+1; spike_count includes it; the next tick's bank lacks bit 7.
//  4 Range: NUM_AXONS=200, packet idx 250
//    -> popped, no bitmap bit set, count unchanged, range_error=1 and sticky until reset.
//  5 Duplicates + double tick: idx 9 three times, tick, tick
//    -> first tick: bit9=1, count=3; second tick: bitmap all 0, count=0.
//  6 Async reset mid-burst: assert reset while both sides are popping
//    -> ren_*=0, axon_spikes=0, spike_count=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/local_spike_sink_pkg.sv
// Shared local-packet geometry for the spike sink and the forwarding stages that feed it.
package local_spike_sink_pkg;

  localparam int unsigned DefLocalWidth = 12;
  localparam int unsigned DefAxonMsb    = 7;
  localparam int unsigned DefNumAxons   = 256;
  localparam int unsigned DefCntWidth   = 16;

  typedef enum logic {
    SideNorth = 1'b0,
    SideSouth = 1'b1
  } side_e;

endpackage

// File: rtl/local_spike_sink_rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer only moves when both sides contend.
module rr_arbiter2
  import local_spike_sink_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o
);

  side_e ptr_q, ptr_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_q <= SideNorth;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Grant is masked during reset so no pop can complete in a reset cycle.
  always_comb begin
    grant_o = 2'b00;
    ptr_d   = ptr_q;
    if (!reset_i) begin
      unique case (req_i)
        2'b01: grant_o = 2'b01;
        2'b10: grant_o = 2'b10;
        2'b11: begin
          grant_o = (ptr_q == SideNorth) ? 2'b01 : 2'b10;
          ptr_d   = (ptr_q == SideNorth) ? SideSouth : SideNorth;
        end
        default: grant_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/local_spike_sink.sv
// Pops local packets from north/south buffers into a double-banked axon bitmap swapped on tick.
module local_spike_sink
  import local_spike_sink_pkg::*;
#(
  parameter int unsigned LocalWidth = DefLocalWidth,
  parameter int unsigned AxonMsb    = DefAxonMsb,
  parameter int unsigned NumAxons   = DefNumAxons,
  parameter int unsigned CntWidth   = DefCntWidth
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [LocalWidth-1:0] din_north_i,
  input  logic                  empty_north_i,
  output logic                  ren_north_o,
  input  logic [LocalWidth-1:0] din_south_i,
  input  logic                  empty_south_i,
  output logic                  ren_south_o,
  input  logic                  tick_i,
  output logic [NumAxons-1:0]   axon_spikes_o,
  output logic [CntWidth-1:0]   spike_count_o,
  output logic                  range_error_o
);

  logic [1:0]            req, grant;
  logic                  pop, in_range, hit;
  logic [LocalWidth-1:0] pkt;
  logic [AxonMsb:0]      idx;
  logic                  unused_pkt_hi;
  logic [CntWidth-1:0]   cnt_inc;

  logic [NumAxons-1:0] bank_q [2];
  logic [NumAxons-1:0] bank_d [2];
  logic                bank_sel_q, bank_sel_d;
  logic [CntWidth-1:0] spike_cnt_q, spike_cnt_d;
  logic [CntWidth-1:0] spike_count_q, spike_count_d;
  logic                range_error_q, range_error_d;

  assign req = {~empty_south_i, ~empty_north_i};

  rr_arbiter2 u_arb (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .req_i   (req),
    .grant_o (grant)
  );

  assign ren_north_o   = grant[0];
  assign ren_south_o   = grant[1];
  assign pop           = |grant;
  assign pkt           = grant[1] ? din_south_i : din_north_i;
  assign idx           = pkt[AxonMsb:0];
  assign unused_pkt_hi = ^pkt[LocalWidth-1:AxonMsb+1];
  assign in_range      = 32'(idx) < NumAxons;
  assign hit           = pop & in_range;
  assign cnt_inc       = (hit && spike_cnt_q != '1) ? spike_cnt_q + 1'b1 : spike_cnt_q;

  // A pop in the tick cycle lands in the bank that is about to become active.
  always_comb begin
    bank_d        = bank_q;
    bank_sel_d    = bank_sel_q;
    spike_count_d = spike_count_q;
    spike_cnt_d   = cnt_inc;
    range_error_d = range_error_q | (pop & ~in_range);
    if (hit) begin
      bank_d[~bank_sel_q][idx] = 1'b1;
    end
    if (tick_i) begin
      bank_sel_d         = ~bank_sel_q;
      bank_d[bank_sel_q] = '0;
      spike_count_d      = cnt_inc;
      spike_cnt_d        = '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bank_q[0]     <= '0;
      bank_q[1]     <= '0;
      bank_sel_q    <= 1'b0;
      spike_cnt_q   <= '0;
      spike_count_q <= '0;
      range_error_q <= 1'b0;
    end else begin
      bank_q[0]     <= bank_d[0];
      bank_q[1]     <= bank_d[1];
      bank_sel_q    <= bank_sel_d;
      spike_cnt_q   <= spike_cnt_d;
      spike_count_q <= spike_count_d;
      range_error_q <= range_error_d;
    end
  end

  assign axon_spikes_o = bank_q[bank_sel_q];
  assign spike_count_o = spike_count_q;
  assign range_error_o = range_error_q;

endmodule

// File: tb/tb_local_spike_sink.sv
// Scoreboard bench for local_spike_sink: per-tick spike sets modelled with plain arrays and queues.
module tb_local_spike_sink;

  localparam int LW = 12;
  localparam int NA = 200;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [LW-1:0] din_north, din_south;
  logic          empty_north, empty_south, ren_north, ren_south, tick;
  logic [NA-1:0] axon_spikes;
  logic [CW-1:0] spike_count;
  logic          range_error;

  local_spike_sink #(
    .LocalWidth (LW),
    .AxonMsb    (7),
    .NumAxons   (NA),
    .CntWidth   (CW)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .din_north_i   (din_north),
    .empty_north_i (empty_north),
    .ren_north_o   (ren_north),
    .din_south_i   (din_south),
    .empty_south_i (empty_south),
    .ren_south_o   (ren_south),
    .tick_i        (tick),
    .axon_spikes_o (axon_spikes),
    .spike_count_o (spike_count),
    .range_error_o (range_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rn;
    logic          rs;
    logic [NA-1:0] sp;
    logic [CW-1:0] cnt;
    logic          re;
  } exp_t;

  exp_t          exp_q[$];
  logic [LW-1:0] qn[$];
  logic [LW-1:0] qs[$];

  // Reference model: set of axons hit in the current tick, and the set/count of the last tick.
  logic [NA-1:0] m_fill, m_active;
  int            m_cnt, m_count;
  bit            m_rerr, m_rr_south;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [NA-1:0] act, input logic [NA-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fill = '0; m_active = '0; m_cnt = 0; m_count = 0; m_rerr = 0; m_rr_south = 0;
  endtask

  task automatic drive_inputs();
    empty_north = (qn.size() == 0);
    empty_south = (qs.size() == 0);
    din_north   = empty_north ? LW'($urandom) : qn[0];
    din_south   = empty_south ? LW'($urandom) : qs[0];
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic cycle(input bit tk);
    exp_t          e;
    bit            n, s, gn, gs;
    logic [LW-1:0] pkt;
    int            idx;
    tick = tk;
    drive_inputs();
    @(negedge clk);
    n = qn.size() > 0;
    s = qs.size() > 0;
    gn = 0; gs = 0;
    if (n && s) begin
      if (m_rr_south) gs = 1; else gn = 1;
      m_rr_south = !m_rr_south;
    end else if (n) gn = 1;
    else if (s) gs = 1;
    e.rn = gn; e.rs = gs; e.sp = m_active; e.cnt = CW'(m_count); e.re = m_rerr;
    exp_q.push_back(e);
    if (gn || gs) begin
      pkt = gn ? qn.pop_front() : qs.pop_front();
      idx = int'(pkt[7:0]);
      if (idx < NA) begin
        m_fill[idx] = 1'b1;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end else begin
        m_rerr = 1;
      end
    end
    if (tk) begin
      m_active = m_fill; m_count = m_cnt; m_fill = '0; m_cnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] mkpkt(input int idx);
    return {4'($urandom), 8'(idx)};
  endfunction

  // Monitor: compares DUT outputs with the queued expectation, away from the clock edge.
  exp_t me;
  always @(negedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      chk("ren_north", NA'(ren_north), NA'(me.rn));
      chk("ren_south", NA'(ren_south), NA'(me.rs));
      chk("axon_spikes", axon_spikes, me.sp);
      chk("spike_count", NA'(spike_count), NA'(me.cnt));
      chk("range_error", NA'(range_error), NA'(me.re));
    end
  end

  logic [NA-1:0] mask;

  initial begin
    reset = 1'b1; tick = 1'b0;
    model_reset();
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ren_north", NA'(ren_north), '0);
    chk("reset_spikes", axon_spikes, '0);
    chk("reset_count", NA'(spike_count), '0);
    chk("reset_range_error", NA'(range_error), '0);
    reset = 1'b0;

    // Single pop of idx 5
    qn.push_back(mkpkt(5));
    cycle(0); cycle(0); cycle(1);
    chk("t1_bit5", NA'(axon_spikes[5]), NA'(1));
    chk("t1_count", NA'(spike_count), NA'(1));

    // Contention: alternating grants, 8 pops in 8 cycles
    for (int i = 0; i < 4; i++) begin
      qn.push_back(mkpkt(1 + i));
      qs.push_back(mkpkt(10 + i));
    end
    repeat (8) cycle(0);
    chk("t2_drained", NA'(qn.size() + qs.size()), '0);
    cycle(1);
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      mask[1 + i] = 1'b1;
      mask[10 + i] = 1'b1;
    end
    chk("t2_spikes", axon_spikes, mask);
    chk("t2_count", NA'(spike_count), NA'(8));

    // Pop in the tick cycle
    qn.push_back(mkpkt(7));
    cycle(1);
    mask = '0; mask[7] = 1'b1;
    chk("t3_spikes", axon_spikes, mask);
    chk("t3_count", NA'(spike_count), NA'(1));
    cycle(0); cycle(1);
    chk("t3_next_bank", axon_spikes, '0);
    chk("t3_next_count", NA'(spike_count), '0);

    // Out-of-range index
    qs.push_back(mkpkt(250));
    cycle(0); cycle(0);
    chk("t4_range_error", NA'(range_error), NA'(1));
    cycle(1);
    chk("t4_spikes", axon_spikes, '0);
    chk("t4_count", NA'(spike_count), '0);

    // Duplicates then a double tick
    repeat (3) qn.push_back(mkpkt(9));
    repeat (3) cycle(0);
    cycle(1);
    mask = '0; mask[9] = 1'b1;
    chk("t5_spikes", axon_spikes, mask);
    chk("t5_count", NA'(spike_count), NA'(3));
    cycle(1);
    chk("t5_empty_spikes", axon_spikes, '0);
    chk("t5_empty_count", NA'(spike_count), '0);
    chk("t5_range_sticky", NA'(range_error), NA'(1));

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      if (qn.size() < 8 && $urandom_range(0, 3) != 0) qn.push_back(mkpkt($urandom_range(0, 255)));
      if (qs.size() < 8 && $urandom_range(0, 3) != 0) qs.push_back(mkpkt($urandom_range(0, 255)));
      cycle($urandom_range(0, 15) == 0);
    end

    // Async reset while both sides are popping
    for (int i = 0; i < 6; i++) begin
      qn.push_back(mkpkt($urandom_range(0, NA - 1)));
      qs.push_back(mkpkt($urandom_range(0, NA - 1)));
    end
    cycle(0); cycle(1); cycle(0);
    @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_ren_north", NA'(ren_north), '0);
    chk("rst_ren_south", NA'(ren_south), '0);
    chk("rst_spikes", axon_spikes, '0);
    chk("rst_count", NA'(spike_count), '0);
    chk("rst_range_error", NA'(range_error), '0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) cycle(0);
    cycle(1);
    for (int c = 0; c < 300; c++) begin
      if (qn.size() < 8 && $urandom_range(0, 1) != 0) qn.push_back(mkpkt($urandom_range(0, NA - 1)));
      if (qs.size() < 8 && $urandom_range(0, 1) != 0) qs.push_back(mkpkt($urandom_range(0, NA - 1)));
      cycle($urandom_range(0, 7) == 0);
    end
    cycle(1);
    @(negedge clk);
    #4;
    chk("scoreboard_drained", NA'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
